mux_replay_buffer: RTL
======================

# mux_replay_buffer

Parametrised, double-banked spike replay buffer for the multiplexed macro column. It captures NUM_CH parallel P-bit spike streams over one gamma window. At each gamma boundary it replays the captured window, one channel after another, as a single time-multiplexed stream toward a shared column. Downstream back-pressure is handled through a valid/ready handshake.

## Interface
- P, 64, spike vector width per channel
- NUM_CH, 2, number of input channels multiplexed onto the output (≥2)
- DEPTH, 16, slots captured per channel per gamma window (≥2, power of two)
- clk  in  1  single clock, all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- grst  in  1  gamma reset; a rising edge (high now, low previous cycle) marks the gamma boundary
- start_count  in  1  capture enable; when high, data_in is written this cycle
- data_in  in  NUM_CH*P  channel c occupies bits [c*P +: P]
- out_ready  in  1  downstream accepts the current beat
- data_out  out  P  replayed spike vector (registered)
- out_valid  out  1  data_out/out_ch/out_slot/out_last are valid
- out_ch  out  max(1,$clog2(NUM_CH))  channel of current beat
- out_slot  out  $clog2(DEPTH)  slot index of current beat
- out_last  out  1  last beat of the current replay
- busy  out  1  replay in progress (out_valid pending)
- overrun  out  1  sticky: a boundary arrived while a replay was still in progress
- cap_ovf  out  1  sticky: a write was attempted with the capture bank full

## Operation
- Storage is two banks, each NUM_CH × DEPTH × P bits. bank_sel selects the capture bank; the other bank is the replay bank.
- rst (async) clears to zero: bank_sel, wr_ptr, rp_len, rd_ch, rd_slot, the grst edge register, data_out, out_valid, out_ch, out_slot, out_last, busy, overrun and cap_ovf. Bank contents are not cleared. rp_len gating prevents stale slots from ever being replayed.
- Capture: wr_ptr is $clog2(DEPTH)+1 bits wide.
  - If start_count && wr_ptr<DEPTH, all NUM_CH slices are written at slot wr_ptr, and wr_ptr increments.
  - If start_count && wr_ptr==DEPTH, the write is dropped and cap_ovf is set.
- Boundary cycle (grst edge detected):
  - rp_len is loaded with the wr_ptr value from before this cycle, and bank_sel toggles.
  - The capture for this cycle targets the new bank at slot 0. wr_ptr becomes start_count ? 1 : 0.
- FSM states are IDLE and REPLAY.
  - IDLE → REPLAY on a boundary with rp_len_new>0. The first beat (ch 0, slot 0) is loaded into the output register on the same edge.
  - Boundary with rp_len_new==0: go to or stay in IDLE, with no beats.
  - REPLAY order is channel-major: ch 0 slots 0..rp_len-1, then ch 1, and so on. Total beats = NUM_CH*rp_len.
  - Advance only on out_valid && out_ready. out_last is high on the beat (ch NUM_CH-1, slot rp_len-1). Accepting that beat leads to IDLE, with out_valid=0 and busy=0.
  - Boundary while in REPLAY: set overrun and discard the remaining beats. Restart from beat 0 of the newly swapped bank, or go to IDLE if its rp_len==0.
- Boundary has priority over the handshake in the same cycle; the accepted beat is simply not followed.
- data_out, out_ch, out_slot and out_last hold stable while out_valid && !out_ready.
- A level-high grst held for multiple cycles counts as one boundary only.

## Timing
- Capture latency: a written sample is replayable after the next boundary.
- Boundary at edge t: out_valid=1 with beat 0 visible after edge t. Sustained throughput is 1 beat/cycle with out_ready=1.
- Full replay with out_ready held high occupies NUM_CH*rp_len cycles after the boundary. For no overrun, the gamma period must be ≥ NUM_CH*rp_len+1 cycles.
- busy == out_valid at all times.
- Sticky flags update on the edge of the causing event and clear only on rst.

## Test plan
- Bench parameters: P=8, NUM_CH=2, DEPTH=4.
- Basic replay:
  - Stimulus: start_count for 4 cycles, ch0 data 01,02,03,04 and ch1 data 11,12,13,14, then a grst edge with out_ready=1.
  - Required: 8 consecutive beats 01,02,03,04,11,12,13,14; out_ch 0,0,0,0,1,1,1,1; out_slot 0..3 repeated; out_last on the 8th beat only.
- Back-pressure:
  - Stimulus: same data, out_ready toggling 1,0,0,1,...
  - Required: no beat lost or duplicated; outputs stable during stalls; same 8-beat sequence.
- Partial and overflow:
  - Stimulus: 2 writes in one window (A1,A2 / B1,B2) → boundary.
  - Required: 4 beats A1,A2,B1,B2.
  - Stimulus: a later window with 6 writes.
  - Required: cap_ovf=1, only the first 4 slots replayed.
- Overrun:
  - Stimulus: a second boundary 3 cycles after the first (out_ready=1).
  - Required: overrun=1; replay restarts at ch0 slot0 of the new bank; the old bank's remaining 5 beats are never emitted.
- Empty window and boundary-cycle write:
  - Stimulus: boundary with 0 writes.
  - Required: out_valid stays 0.
  - Stimulus: a write with start_count high on the boundary cycle, value 5A.
  - Required: 5A appears as slot 0 of the next replay.
- Async reset mid-replay:
  - Stimulus: assert rst between clock edges during beat 3.
  - Required: all outputs 0 immediately; after release, a boundary with no writes produces no beats.

Source files
------------

// File: rtl/mux_replay_buffer.sv
// Double-banked spike replay buffer: captures NUM_CH parallel P-bit streams per gamma window
// and replays the previous window channel-major as one valid/ready stream.
module mux_replay_buffer #(
  parameter int P = 64,
  parameter int NUM_CH = 2,
  parameter int DEPTH = 16,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int SW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                grst,
  input  logic                start_count,
  input  logic [NUM_CH*P-1:0] data_in,
  input  logic                out_ready,
  output logic [P-1:0]        data_out,
  output logic                out_valid,
  output logic [CHW-1:0]      out_ch,
  output logic [SW-1:0]       out_slot,
  output logic                out_last,
  output logic                busy,
  output logic                overrun,
  output logic                cap_ovf
);

  localparam int PW = SW + 1;
  localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CH - 1);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] REPLAY = 1'b1;

  logic [P-1:0]    mem_r [2][NUM_CH][DEPTH];
  logic            bank_sel_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rp_len_r;
  logic [CHW-1:0]  rd_ch_r;
  logic [SW-1:0]   rd_slot_r;
  logic            grst_q_r;
  logic [0:0]      state_r;

  logic            boundary_s;
  logic            full_s;
  logic            wr_en_s;
  logic            wr_bank_s;
  logic [SW-1:0]   wr_slot_s;
  logic            rp_bank_s;
  logic [CHW-1:0]  nxt_ch_s;
  logic [SW-1:0]   nxt_slot_s;
  logic            nxt_last_s;
  logic            first_last_s;

  assign boundary_s   = grst && !grst_q_r;
  assign full_s       = (wr_ptr_r == PW'(DEPTH));
  assign rp_bank_s    = ~bank_sel_r;
  assign first_last_s = (LAST_CH == '0) && (wr_ptr_r == PW'(1));

  // Capture address: a boundary redirects this cycle's write to slot 0 of the bank about to become active.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_bank_s = bank_sel_r;
    wr_slot_s = wr_ptr_r[SW-1:0];
    if (boundary_s) begin
      wr_en_s   = start_count;
      wr_bank_s = ~bank_sel_r;
      wr_slot_s = '0;
    end else begin
      wr_en_s = start_count && !full_s;
    end
  end

  // Next beat in channel-major order within the replayed length.
  always_comb begin
    nxt_ch_s   = rd_ch_r;
    nxt_slot_s = rd_slot_r + SW'(1);
    if ({1'b0, rd_slot_r} == rp_len_r - PW'(1)) begin
      nxt_ch_s   = rd_ch_r + CHW'(1);
      nxt_slot_s = '0;
    end else begin
      nxt_ch_s   = rd_ch_r;
    end
    nxt_last_s = (nxt_ch_s == LAST_CH) && ({1'b0, nxt_slot_s} == rp_len_r - PW'(1));
  end

  // Spike storage; contents are never reset since rp_len gates what is replayed.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mem_r[wr_bank_s][c][wr_slot_s] <= data_in[c*P +: P];
      end
    end
  end

  // Capture pointer, bank swap, replay FSM and registered output beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_sel_r <= 1'b0;
      wr_ptr_r   <= '0;
      rp_len_r   <= '0;
      rd_ch_r    <= '0;
      rd_slot_r  <= '0;
      grst_q_r   <= 1'b0;
      state_r    <= IDLE;
      data_out   <= '0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_slot   <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      cap_ovf    <= 1'b0;
    end else begin
      grst_q_r <= grst;
      if (boundary_s) begin
        bank_sel_r <= ~bank_sel_r;
        rp_len_r   <= wr_ptr_r;
        wr_ptr_r   <= start_count ? PW'(1) : PW'(0);
        rd_ch_r    <= '0;
        rd_slot_r  <= '0;
        if (state_r == REPLAY) begin
          overrun <= 1'b1;
        end
        if (wr_ptr_r != '0) begin
          state_r   <= REPLAY;
          data_out  <= mem_r[bank_sel_r][0][0];
          out_valid <= 1'b1;
          busy      <= 1'b1;
          out_ch    <= '0;
          out_slot  <= '0;
          out_last  <= first_last_s;
        end else begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          out_last  <= 1'b0;
        end
      end else begin
        if (start_count) begin
          if (full_s) begin
            cap_ovf <= 1'b1;
          end else begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
          end
        end
        if (out_valid && out_ready) begin
          if (out_last) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_last  <= 1'b0;
          end else begin
            rd_ch_r   <= nxt_ch_s;
            rd_slot_r <= nxt_slot_s;
            data_out  <= mem_r[rp_bank_s][nxt_ch_s][nxt_slot_s];
            out_ch    <= nxt_ch_s;
            out_slot  <= nxt_slot_s;
            out_last  <= nxt_last_s;
          end
        end
      end
    end
  end

endmodule
